alarm_sequencer: RTL

//  Alarm controller for the clock/alarm display. Compares running time to stored alarm time and sequences ring, snooze and dismiss.

---
 rtl/alarm_pkg.sv | 12 +
 rtl/alarm_sec_timer.sv | 18 +
 rtl/alarm_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: state encodings, BCD time width and default timeouts for the alarm sequencer.
package alarm_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SNOOZE   = 2'd2,
        SILENCED = 2'd3
    } alarm_state_e;
    localparam int TIME_W      = 16;
    localparam int RING_DEF_S  = 60;
    localparam int SNOOZE_DEF_S = 300;
endpackage

// File: rtl/alarm_sec_timer.sv
// alarm_sec_timer: tick-driven saturating second counter with clear and terminal-count flag.
module alarm_sec_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         tick_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (tick_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    assign tc_o = cnt_q == tc_val_i;
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: sequences ring, snooze and dismiss from a running-time/alarm-time match.
// Define ALARM_SNOOZE_EN to enable the SNOOZE state; otherwise btn_snooze acts as dismiss.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = RING_DEF_S,
    parameter int SNOOZE_S       = SNOOZE_DEF_S,
    parameter int BLINK_TICKS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [TIME_W-1:0] cur_time,
    input  logic [TIME_W-1:0] alm_time,
    input  logic              clock_run,
    input  logic              armed,
    input  logic              btn_dismiss,
    input  logic              btn_snooze,
    output logic              ringing,
    output logic              buzz,
    output logic              snoozed,
    output logic [1:0]        state_o
);
`ifdef ALARM_SNOOZE_EN
    localparam int CNT_MAX = RING_TIMEOUT_S > SNOOZE_S ? RING_TIMEOUT_S : SNOOZE_S;
`else
    localparam int CNT_MAX = RING_TIMEOUT_S;
`endif
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] RING_TC = CNT_W'(RING_TIMEOUT_S - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_TICKS - 1);
    alarm_state_e state_q, state_d;
    logic match, match_q, primed_q, trigger, clr, cnt_en, tc, dismiss, snooze_req;
    logic phase_q, phase_d, ringing_q, buzz_q;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [1:0] st_q;
    logic [CNT_W-1:0] tc_val;
    assign match = armed & clock_run & (cur_time == alm_time);
    // primed_q keeps a match already true at reset release from counting as a rising edge
    assign trigger = match & ~match_q & primed_q;
    assign cnt_en = tick_1hz & ~btn_dismiss & ~btn_snooze & (state_q == RINGING || state_q == SNOOZE);
    assign clr = state_d != state_q;
`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_TC = CNT_W'(SNOOZE_S - 1);
    logic snoozed_q;
    assign dismiss = btn_dismiss;
    assign snooze_req = btn_snooze;
    assign tc_val = state_q == SNOOZE ? SNOOZE_TC : RING_TC;
    assign snoozed = snoozed_q;
`else
    assign dismiss = btn_dismiss | btn_snooze;
    assign snooze_req = 1'b0;
    assign tc_val = RING_TC;
    assign snoozed = 1'b0;
`endif
    alarm_sec_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .tick_i   (cnt_en),
        .tc_val_i (tc_val),
        .tc_o     (tc)
    );
    always_comb begin
        state_d = state_q;
        if (!armed) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:     if (trigger) state_d = RINGING;
                RINGING:  if (dismiss) state_d = SILENCED;
                          else if (snooze_req) state_d = SNOOZE;
                          else if (tick_1hz && tc) state_d = SILENCED;
`ifdef ALARM_SNOOZE_EN
                SNOOZE:   if (btn_dismiss) state_d = IDLE;
                          else if (cnt_en && tc) state_d = RINGING;
`endif
                SILENCED: if (!match) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end
    always_comb begin
        phase_d = phase_q;
        bcnt_d = bcnt_q;
        if (state_d != RINGING) begin
            phase_d = 1'b0;
            bcnt_d = '0;
        end else if (state_q != RINGING) begin
            phase_d = 1'b1;
            bcnt_d = '0;
        end else if (tick_1hz) begin
            phase_d = bcnt_q == BLINK_TC ? ~phase_q : phase_q;
            bcnt_d = bcnt_q == BLINK_TC ? '0 : bcnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            match_q <= 1'b0;
            primed_q <= 1'b0;
            phase_q <= 1'b0;
            bcnt_q <= '0;
            ringing_q <= 1'b0;
            buzz_q <= 1'b0;
            st_q <= 2'd0;
        end else begin
            state_q <= state_d;
            match_q <= match;
            primed_q <= 1'b1;
            phase_q <= phase_d;
            bcnt_q <= bcnt_d;
            ringing_q <= state_q == RINGING;
            buzz_q <= (state_q == RINGING) & phase_q;
            st_q <= state_q;
        end
    end
`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) snoozed_q <= 1'b0;
        else      snoozed_q <= state_q == SNOOZE;
`endif
    assign ringing = ringing_q;
    assign buzz = buzz_q;
    assign state_o = st_q;
endmodule
